id_ctrl: RTL and testbench

Decode stage and multi-cycle sequencer directly downstream of the instruction-fetch stage. Generates the IR_Write/PC_Write strobes that drive fetch, then consumes the latched 32-bit RV32 instruction. Splits the instruction into fields, generates the immediate, and reads the integrated register file into operand latches A/B. Hands operands to the execute stage with a valid/ready handshake and performs register write-back when execute returns a result.

---
 rtl/id_pkg.sv | 67 ++++++
 rtl/id_ctrl_regfile.sv | 52 +++++
 rtl/id_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_id_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// ============================================================================
//  Module      : id_pkg
//  Description : Shared definitions for the id_ctrl decode/sequencer slice:
//                sequencer state encoding, RV32 opcode values and the bit
//                positions of the instruction fields.
//                Optional feature macro: ILLEGAL_TRAP_EN (adds S_HALT).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_pkg;

    // Sequencer states. S_HALT only exists when illegal-opcode trapping is built in.
`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WB     = 3'd4
    } state_t;
`endif

    // RV32 base opcodes recognised by the decoder
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Least-significant bit of each instruction field
    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    // True for every opcode the decoder knows how to form an immediate for,
    // plus the register-register form (which has no immediate).
    function automatic logic is_known_opcode(input logic [6:0] op);
        logic known;
        known = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_JALR, OP_S,
            OP_B, OP_LUI, OP_AUIPC, OP_JAL: known = 1'b1;
            default:                        known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ctrl_regfile.sv
// ============================================================================
//  Module      : id_ctrl_regfile
//  Description : REG_NUM x DATA_W architectural register file. Two
//                combinational read ports, one synchronous write port.
//                x0 is not stored: it always reads zero and ignores writes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ctrl_regfile #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int AW      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] w_mem [REG_NUM];

    // x0 has no storage; it is a constant zero
    assign w_mem[0] = '0;

    for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_reg
        logic [DATA_W-1:0] r_q;

        // One architectural register: cleared by reset, loaded on a matching write
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (i_we && (i_waddr == AW'(gi))) begin
                r_q <= i_wdata;
            end
        end

        assign w_mem[gi] = r_q;
    end

    // Out-of-range addresses (non power-of-two REG_NUM) read as zero
    assign o_rdata_a = (32'(i_raddr_a) < REG_NUM) ? w_mem[i_raddr_a] : '0;
    assign o_rdata_b = (32'(i_raddr_b) < REG_NUM) ? w_mem[i_raddr_b] : '0;

endmodule

`default_nettype wire

// File: rtl/id_ctrl.sv
// ============================================================================
//  Module      : id_ctrl
//  Description : Decode stage and multi-cycle sequencer. Strobes the fetch
//                stage (IR_Write/PC_Write), decodes the latched RV32
//                instruction, reads operands into A/B, issues to execute with
//                a valid/ready handshake and performs register write-back.
//                Optional feature macro: ILLEGAL_TRAP_EN - unknown opcodes
//                raise the sticky illegal flag and halt until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ctrl
    import id_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst,
    output logic              IR_Write,
    output logic              PC_Write,
    output logic              id_valid,
    input  logic              ex_ready,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] imm,
    input  logic              wb_valid,
    input  logic              wb_en,
    input  logic [DATA_W-1:0] wb_data,
    output logic              illegal
);

    localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    state_t            r_state;
    state_t            w_next;

    logic              r_ir_write;
    logic              r_pc_write;
    logic              r_id_valid;
    logic [6:0]        r_opcode;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_imm;

    logic [6:0]        w_op;
    logic [31:0]       w_imm;
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic              w_we;

    assign w_op = inst[OPCODE_LSB +: 7];

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; handshake inputs only matter in their own state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                if (!is_known_opcode(w_op)) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_ISSUE;
                end
`else
                w_next = S_ISSUE;
`endif
            end
            S_ISSUE:  if (ex_ready) w_next = S_WB;
            S_WB:     if (wb_valid) w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:   w_next = S_HALT;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    // Immediate generation by instruction format; R-type and unknown give zero
    always_comb begin
        w_imm = 32'd0;
        case (w_op)
            OP_I, OP_LOAD, OP_JALR:
                w_imm = {{20{inst[31]}}, inst[31:20]};
            OP_S:
                w_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_B:
                w_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {inst[31:12], 12'd0};
            OP_JAL:
                w_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                w_imm = 32'd0;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free and
    // line up exactly with the FETCH / ISSUE cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_write <= 1'b0;
            r_pc_write <= 1'b0;
            r_id_valid <= 1'b0;
        end else begin
            r_ir_write <= (w_next == S_FETCH);
            r_pc_write <= (w_next == S_FETCH);
            r_id_valid <= (w_next == S_ISSUE);
        end
    end

    // Field and operand latches: loaded once in DECODE, held through ISSUE/WB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
            r_funct3 <= '0;
            r_funct7 <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
        end else if (r_state == S_DECODE) begin
            r_opcode <= w_op;
            r_funct3 <= inst[FUNCT3_LSB +: 3];
            r_funct7 <= inst[FUNCT7_LSB +: 7];
            r_rd     <= inst[RD_LSB +: 5];
            r_a      <= w_rdata_a;
            r_b      <= w_rdata_b;
            r_imm    <= DATA_W'(w_imm);
        end
    end

    // Write-back only from S_WB; the register file also masks x0
    assign w_we = (r_state == S_WB) && wb_valid && wb_en && (r_rd != 5'd0);

    id_ctrl_regfile #(
        .REG_NUM (REG_NUM),
        .DATA_W  (DATA_W),
        .AW      (AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_raddr_a (inst[RS1_LSB +: AW]),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (inst[RS2_LSB +: AW]),
        .o_rdata_b (w_rdata_b),
        .i_we      (w_we),
        .i_waddr   (r_rd[AW-1:0]),
        .i_wdata   (wb_data)
    );

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_DECODE) && (w_next == S_HALT)) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign IR_Write = r_ir_write;
    assign PC_Write = r_pc_write;
    assign id_valid = r_id_valid;
    assign opcode   = r_opcode;
    assign funct3   = r_funct3;
    assign funct7   = r_funct7;
    assign rd       = r_rd;
    assign A        = r_a;
    assign B        = r_b;
    assign imm      = r_imm;

endmodule

`default_nettype wire

// File: tb/tb_id_ctrl.sv
// ============================================================================
//  Module      : tb_id_ctrl
//  Description : Self-checking bench for id_ctrl. Emulates the fetch-stage IR
//                and the execute stage, and keeps a reference register file
//                and immediate decoder built from the instruction-set rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'd0;
    logic        ex_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_en = 1'b0;
    logic [31:0] wb_data = 32'd0;

    logic        IR_Write, PC_Write, id_valid, illegal;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] A, B, imm;

    int total = 0;
    int bad   = 0;

    logic [31:0] mreg [32];

    id_ctrl #(.REG_NUM(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inst     (inst),
        .IR_Write (IR_Write),
        .PC_Write (PC_Write),
        .id_valid (id_valid),
        .ex_ready (ex_ready),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rd       (rd),
        .A        (A),
        .B        (B),
        .imm      (imm),
        .wb_valid (wb_valid),
        .wb_en    (wb_en),
        .wb_data  (wb_data),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic known_op(input logic [6:0] op);
        return (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h67) ||
               (op == 7'h23) || (op == 7'h63) || (op == 7'h37) || (op == 7'h17) ||
               (op == 7'h6F);
    endfunction

    // Immediate as defined by the RV32 format rules
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: v = $signed(i[31:20]);
            7'h23:               v = $signed({i[31:25], i[11:7]});
            7'h63:               v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            7'h37, 7'h17:        v = int'(i[31:12]) * 4096;
            7'h6F:               v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            default:             v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mreg[a];
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 32; k++) mreg[k] = 32'd0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_irw"},  {31'd0, IR_Write}, 32'd0);
        chk({tag, "_pcw"},  {31'd0, PC_Write}, 32'd0);
        chk({tag, "_vld"},  {31'd0, id_valid}, 32'd0);
        chk({tag, "_ill"},  {31'd0, illegal},  32'd0);
        chk({tag, "_fld"},  {13'd0, opcode, funct3, funct7, rd}, 32'd0);
        chk({tag, "_A"},    A,   32'd0);
        chk({tag, "_B"},    B,   32'd0);
        chk({tag, "_imm"},  imm, 32'd0);
    endtask

    // Wait (bounded) for the fetch strobe, then present the new IR contents
    task automatic do_fetch(input logic [31:0] ins);
        int n;
        n = 0;
        while (IR_Write !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_irw", {31'd0, IR_Write}, 32'd1);
        chk("fetch_pcw", {31'd0, PC_Write}, 32'd1);
        inst = ins;
        @(negedge clk);
        chk("decode_vld", {31'd0, id_valid}, 32'd0);
        chk("decode_irw", {31'd0, IR_Write}, 32'd0);
        @(negedge clk);
    endtask

    // One full instruction: fetch, decode, issue (with stall), write-back (with wait)
    task automatic run_instr(input logic [31:0] ins, input int stall, input int wbwait,
                             input logic we, input logic [31:0] wd);
        logic [31:0] e_a, e_b, e_imm;
        e_a   = ref_read(ins[19:15]);
        e_b   = ref_read(ins[24:20]);
        e_imm = ref_imm(ins);
        do_fetch(ins);
`ifdef ILLEGAL_TRAP_EN
        if (!known_op(ins[6:0])) begin
            chk("halt_ill", {31'd0, illegal},  32'd1);
            chk("halt_vld", {31'd0, id_valid}, 32'd0);
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk("halt_irw", {30'd0, IR_Write, PC_Write}, 32'd0);
                chk("halt_vld", {31'd0, id_valid}, 32'd0);
            end
            return;
        end
`endif
        chk("issue_vld",    {31'd0, id_valid}, 32'd1);
        chk("issue_ill",    {31'd0, illegal},  32'd0);
        chk("issue_opcode", {25'd0, opcode}, {25'd0, ins[6:0]});
        chk("issue_funct3", {29'd0, funct3}, {29'd0, ins[14:12]});
        chk("issue_funct7", {25'd0, funct7}, {25'd0, ins[31:25]});
        chk("issue_rd",     {27'd0, rd},     {27'd0, ins[11:7]});
        chk("issue_A",      A,   e_a);
        chk("issue_B",      B,   e_b);
        chk("issue_imm",    imm, e_imm);
        // Stall: a stray write-back offered here must be ignored
        for (int k = 0; k < stall; k++) begin
            wb_valid = 1'b1;
            wb_en    = 1'b1;
            wb_data  = $urandom;
            @(negedge clk);
            chk("stall_vld", {31'd0, id_valid}, 32'd1);
            chk("stall_irw", {30'd0, IR_Write, PC_Write}, 32'd0);
            chk("stall_A",   A,   e_a);
            chk("stall_B",   B,   e_b);
            chk("stall_imm", imm, e_imm);
        end
        wb_valid = 1'b0;
        wb_en    = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        ex_ready = 1'b0;
        chk("wb_vld", {31'd0, id_valid}, 32'd0);
        for (int k = 0; k < wbwait; k++) begin
            @(negedge clk);
            chk("wbwait_irw", {31'd0, IR_Write}, 32'd0);
        end
        wb_valid = 1'b1;
        wb_en    = we;
        wb_data  = wd;
        @(negedge clk);
        wb_valid = 1'b0;
        wb_en    = 1'b0;
        chk("next_fetch_irw", {31'd0, IR_Write}, 32'd1);
        if (we && ins[11:7] != 5'd0) mreg[ins[11:7]] = wd;
    endtask

    logic [6:0] ops [10];

    initial begin
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
        clear_model();

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // One IDLE cycle, then the first fetch strobe
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_irw", {31'd0, IR_Write}, 32'd0);
        @(negedge clk);
        chk("first_fetch", {30'd0, IR_Write, PC_Write}, 32'd3);

        // Directed: addi x1,x0,5 then a read of x1
        run_instr(32'h00500093, 0, 0, 1'b1, 32'd5);
        run_instr(32'h00008113, 0, 0, 1'b1, 32'd5);
        // Branch with negative offset, LUI with top bit set
        run_instr(32'hFE000EE3, 0, 0, 1'b0, 32'd0);
        run_instr(32'h800000B7, 0, 0, 1'b1, 32'h80000000);
        // Five-cycle execute stall with stray write-back offers
        run_instr(32'h002081B3, 5, 2, 1'b1, 32'h12345678);
        // Write to x0 discarded; then read x0 on both ports
        run_instr(32'h00000013, 0, 0, 1'b1, 32'hDEADBEEF);
        run_instr(32'h00000233, 0, 0, 1'b1, 32'h0);
        // Store, JAL, and a read of the registers written above
        run_instr(32'h8030A523, 1, 0, 1'b0, 32'h0);
        run_instr(32'h7FF0016F, 0, 1, 1'b1, 32'hCAFEF00D);

        // Randomised instructions
        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 9)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) r[6:0] = 7'(($urandom_range(0, 127)) | 1);
`endif
            run_instr(r, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), $urandom);
        end

        // Unknown opcode: issues with imm=0 or halts, depending on build
        run_instr(32'h0000007F, 0, 0, 1'b0, 32'h0);

        // Reset in the middle of a write-back: nothing is written, all clears
        if (IR_Write !== 1'b1) begin
            rst_n = 1'b0;
            @(negedge clk);
            @(posedge clk);
            #1 rst_n = 1'b1;
            clear_model();
        end
        do_fetch(32'h00108093);
        ex_ready = 1'b1;
        @(negedge clk);
        ex_ready = 1'b0;
        wb_valid = 1'b1;
        wb_en    = 1'b1;
        wb_data  = 32'hA5A5A5A5;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        wb_valid = 1'b0;
        wb_en    = 1'b0;
        clear_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_idle", {31'd0, IR_Write}, 32'd0);
        run_instr(32'h00108093, 0, 0, 1'b1, 32'd1);
        run_instr(32'h001081B3, 0, 0, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
